// File: rtl/riscv_instr_arb_pkg.sv
// Shared types for the instruction-port arbiter: master identifiers carried in the ID FIFO.
package riscv_instr_arb_pkg;

    typedef logic instr_mst_id_t;

    localparam instr_mst_id_t MST_CORE = 1'b0;
    localparam instr_mst_id_t MST_NPU  = 1'b1;

endpackage

// File: rtl/riscv_instr_arb_idfifo.sv
// In-order FIFO of master IDs for granted-but-unanswered fetches; supports push and pop in one cycle.
module riscv_instr_arb_idfifo
    import riscv_instr_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  instr_mst_id_t    push_id,
    input  logic             pop,
    output instr_mst_id_t    head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] cnt_next
);

    instr_mst_id_t    mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full   = (cnt_r == CNT_W'(DEPTH));
    assign empty  = (cnt_r == {CNT_W{1'b0}});
    assign head   = mem_r[rptr_r];
    // A push into a full FIFO is only legal when an entry leaves in the same cycle
    assign pop_s  = pop & ~empty;
    assign push_s = push & (~full | pop_s);

    // Occupancy for the next cycle
    always_comb begin
        cnt_next = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_next = cnt_r + CNT_W'(1);
            2'b01:   cnt_next = cnt_r - CNT_W'(1);
            default: cnt_next = cnt_r;
        endcase
    end

    // Pointers, count and ID storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= {PTR_W{1'b0}};
            rptr_r <= {PTR_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= MST_CORE;
            end
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= push_id;
                wptr_r        <= ptr_inc(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            cnt_r <= cnt_next;
        end
    end

endmodule

// File: rtl/riscv_instr_arbiter.sv
// Round-robin arbiter sharing the I-cache request port between the core prefetcher (M0) and NPU loader (M1).
module riscv_instr_arbiter
    import riscv_instr_arb_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [DATA_W-1:0] instr_rdata_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    instr_mst_id_t    sel_s;
    instr_mst_id_t    head_s;
    instr_mst_id_t    lock_id_r;
    instr_mst_id_t    rr_r;
    logic             lock_r;
    logic             sel_req_s;
    logic             grant_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             busy_r;
    logic             err_r;

    // Master selection: a pending ungranted request stays selected so the address cannot change under the cache
    always_comb begin
        sel_s = MST_CORE;
        if (lock_r) begin
            sel_s = lock_id_r;
        end else if (m0_req_i && m1_req_i) begin
            sel_s = ~rr_r;
        end else if (m1_req_i) begin
            sel_s = MST_NPU;
        end else begin
            sel_s = MST_CORE;
        end
    end

    assign sel_req_s    = (sel_s == MST_NPU) ? m1_req_i : m0_req_i;
    assign instr_req_o  = sel_req_s & ~full_s;
    assign instr_addr_o = (sel_s == MST_NPU) ? m1_addr_i : m0_addr_i;
    assign grant_s      = instr_req_o & instr_gnt_i;
    assign m0_gnt_o     = grant_s & (sel_s == MST_CORE);
    assign m1_gnt_o     = grant_s & (sel_s == MST_NPU);

    // Responses return in order, so the FIFO head names their owner
    assign pop_s        = instr_rvalid_i & ~empty_s;
    assign m0_rvalid_o  = pop_s & (head_s == MST_CORE);
    assign m1_rvalid_o  = pop_s & (head_s == MST_NPU);
    assign m0_rdata_o   = instr_rdata_i;
    assign m1_rdata_o   = instr_rdata_i;
    assign busy_o       = busy_r;
    assign err_o        = err_r;

    riscv_instr_arb_idfifo #(
        .DEPTH    (MAX_OUTST)
    ) u_idfifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (grant_s),
        .push_id  (sel_s),
        .pop      (instr_rvalid_i),
        .head     (head_s),
        .full     (full_s),
        .empty    (empty_s),
        .cnt_next (cnt_next_s)
    );

    // Lock, round-robin pointer and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r    <= 1'b0;
            lock_id_r <= MST_CORE;
            rr_r      <= MST_NPU;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            if (grant_s) begin
                lock_r <= 1'b0;
                rr_r   <= sel_s;
            end else if (instr_req_o) begin
                lock_r    <= 1'b1;
                lock_id_r <= sel_s;
            end
            busy_r <= (cnt_next_s != {CNT_W{1'b0}});
            if (instr_rvalid_i && empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_instr_arbiter.sv
// Directed table-driven bench for riscv_instr_arbiter with MAX_OUTST=2.
module tb_riscv_instr_arbiter;

    // in_f = {rst, m0_req, m1_req, gnt, rvalid}; ex_f = {req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, err}
    typedef struct {
        logic [4:0]  in_f;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] rdata;
        logic [6:0]  ex_f;
        logic [31:0] ex_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, instr_gnt, instr_rvalid;
    logic [31:0] m0_addr, m1_addr, instr_rdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, instr_req, busy, err;
    logic [31:0] m0_rdata, m1_rdata, instr_addr;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [32];

    always #5 clk = ~clk;

    riscv_instr_arbiter #(
        .MAX_OUTST (2),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_req_i       (m0_req),
        .m0_addr_i      (m0_addr),
        .m0_gnt_o       (m0_gnt),
        .m0_rvalid_o    (m0_rvalid),
        .m0_rdata_o     (m0_rdata),
        .m1_req_i       (m1_req),
        .m1_addr_i      (m1_addr),
        .m1_gnt_o       (m1_gnt),
        .m1_rvalid_o    (m1_rvalid),
        .m1_rdata_o     (m1_rdata),
        .instr_req_o    (instr_req),
        .instr_addr_o   (instr_addr),
        .instr_gnt_i    (instr_gnt),
        .instr_rvalid_i (instr_rvalid),
        .instr_rdata_i  (instr_rdata),
        .busy_o         (busy),
        .err_o          (err)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        m0_req = 1'b0; m1_req = 1'b0; instr_gnt = 1'b0; instr_rvalid = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h0; instr_rdata = 32'h0;
        rst_n = 1'b0;
        @(negedge clk);
        chk1({tag, " rst req"}, instr_req, 1'b0);
        chk1({tag, " rst m0_gnt"}, m0_gnt, 1'b0);
        chk1({tag, " rst m1_gnt"}, m1_gnt, 1'b0);
        chk1({tag, " rst m0_rvalid"}, m0_rvalid, 1'b0);
        chk1({tag, " rst m1_rvalid"}, m1_rvalid, 1'b0);
        chk1({tag, " rst busy"}, busy, 1'b0);
        chk1({tag, " rst err"}, err, 1'b0);
        chk32({tag, " rst addr"}, instr_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        if (v.in_f[4]) do_reset(tag);
        m0_req       = v.in_f[3];
        m1_req       = v.in_f[2];
        instr_gnt    = v.in_f[1];
        instr_rvalid = v.in_f[0];
        m0_addr      = v.a0;
        m1_addr      = v.a1;
        instr_rdata  = v.rdata;
        @(negedge clk);
        chk1({tag, " req"}, instr_req, v.ex_f[6]);
        chk32({tag, " addr"}, instr_addr, v.ex_addr);
        chk1({tag, " m0_gnt"}, m0_gnt, v.ex_f[5]);
        chk1({tag, " m1_gnt"}, m1_gnt, v.ex_f[4]);
        chk1({tag, " m0_rvalid"}, m0_rvalid, v.ex_f[3]);
        chk1({tag, " m1_rvalid"}, m1_rvalid, v.ex_f[2]);
        chk1({tag, " busy"}, busy, v.ex_f[1]);
        chk1({tag, " err"}, err, v.ex_f[0]);
        if (v.in_f[0]) begin
            chk32({tag, " m0_rdata"}, m0_rdata, v.rdata);
            chk32({tag, " m1_rdata"}, m1_rdata, v.rdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single master M0: grant at once, response two cycles later
        vecs[0]  = '{5'b00000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 7'b0000000, 32'h0000_0000};
        vecs[1]  = '{5'b01010, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 7'b1100000, 32'h0000_1000};
        vecs[2]  = '{5'b00000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 7'b0000010, 32'h0000_0000};
        vecs[3]  = '{5'b00001, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 7'b0001010, 32'h0000_0000};
        vecs[4]  = '{5'b00000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 7'b0000000, 32'h0000_0000};
        // contention after reset: M0, M1, M0, M1 with responses one cycle behind
        vecs[5]  = '{5'b11110, 32'h0000_1000, 32'h0000_2000, 32'h0000_0000, 7'b1100000, 32'h0000_1000};
        vecs[6]  = '{5'b01111, 32'h0000_1000, 32'h0000_2000, 32'h1111_1111, 7'b1011010, 32'h0000_2000};
        vecs[7]  = '{5'b01111, 32'h0000_1000, 32'h0000_2000, 32'h2222_2222, 7'b1100110, 32'h0000_1000};
        vecs[8]  = '{5'b01111, 32'h0000_1000, 32'h0000_2000, 32'h3333_3333, 7'b1011010, 32'h0000_2000};
        vecs[9]  = '{5'b00001, 32'h0000_0000, 32'h0000_0000, 32'h4444_4444, 7'b0000110, 32'h0000_0000};
        vecs[10] = '{5'b00000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 7'b0000000, 32'h0000_0000};
        // lock: M1 waits three cycles for gnt while M0 joins
        vecs[11] = '{5'b00100, 32'h0000_0000, 32'h0000_2000, 32'h0000_0000, 7'b1000000, 32'h0000_2000};
        vecs[12] = '{5'b01100, 32'h0000_1000, 32'h0000_2000, 32'h0000_0000, 7'b1000000, 32'h0000_2000};
        vecs[13] = '{5'b01100, 32'h0000_1000, 32'h0000_2000, 32'h0000_0000, 7'b1000000, 32'h0000_2000};
        vecs[14] = '{5'b01110, 32'h0000_1000, 32'h0000_2000, 32'h0000_0000, 7'b1010000, 32'h0000_2000};
        vecs[15] = '{5'b01010, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 7'b1100010, 32'h0000_1000};
        vecs[16] = '{5'b00001, 32'h0000_0000, 32'h0000_0000, 32'hAAAA_0001, 7'b0000110, 32'h0000_0000};
        vecs[17] = '{5'b00001, 32'h0000_0000, 32'h0000_0000, 32'hAAAA_0002, 7'b0001010, 32'h0000_0000};
        vecs[18] = '{5'b00000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 7'b0000000, 32'h0000_0000};
        // full: two outstanding, request blocked through the rvalid cycle
        vecs[19] = '{5'b01010, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 7'b1100000, 32'h0000_3000};
        vecs[20] = '{5'b00110, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 7'b1010010, 32'h0000_4000};
        vecs[21] = '{5'b01110, 32'h0000_3000, 32'h0000_4000, 32'h0000_0000, 7'b0000010, 32'h0000_3000};
        vecs[22] = '{5'b01111, 32'h0000_3000, 32'h0000_4000, 32'hF0F0_F0F0, 7'b0001010, 32'h0000_3000};
        vecs[23] = '{5'b01110, 32'h0000_3000, 32'h0000_4000, 32'h0000_0000, 7'b1100010, 32'h0000_3000};
        // push and pop together keep count and order
        vecs[24] = '{5'b00111, 32'h0000_0000, 32'h0000_4000, 32'h5555_AAAA, 7'b0000110, 32'h0000_4000};
        vecs[25] = '{5'b00111, 32'h0000_0000, 32'h0000_4000, 32'h1234_5678, 7'b1011010, 32'h0000_4000};
        vecs[26] = '{5'b00001, 32'h0000_0000, 32'h0000_0000, 32'h8765_4321, 7'b0000110, 32'h0000_0000};
        vecs[27] = '{5'b00000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 7'b0000000, 32'h0000_0000};
        // stray response, then leave an outstanding M0 entry and an M1 lock
        vecs[28] = '{5'b00001, 32'h0000_0000, 32'h0000_0000, 32'hBAD0_BAD0, 7'b0000000, 32'h0000_0000};
        vecs[29] = '{5'b00000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 7'b0000001, 32'h0000_0000};
        vecs[30] = '{5'b01010, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 7'b1100001, 32'h0000_1000};
        vecs[31] = '{5'b00100, 32'h0000_0000, 32'h0000_2000, 32'h0000_0000, 7'b1000011, 32'h0000_2000};

        rst_n = 1'b0;
        do_reset("init");
        for (int i = 0; i < 32; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // mid-stream reset clears err, busy, lock and round-robin state: M0 must win next
        do_reset("mid");
        apply('{5'b01110, 32'h0000_1000, 32'h0000_2000, 32'h0000_0000, 7'b1100000, 32'h0000_1000}, "post0");
        apply('{5'b00001, 32'h0000_0000, 32'h0000_0000, 32'hC0DE_0001, 7'b0001010, 32'h0000_0000}, "post1");
        apply('{5'b00000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 7'b0000000, 32'h0000_0000}, "post2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
